// File: rtl/gpu_pkg.sv
// Shared types and default widths for the GPU memory path.
// Provides the arbiter state encoding and the index-width helper.
package gpu_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } arb_state_t;

  // Width of a core index; a single core still needs one bit to carry it.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr wins.
// ptr is always kept below NUM_CORES by the owner.
module rr_picker
  import gpu_pkg::*;
#(
  parameter  int unsigned NUM_CORES = 2,
  localparam int unsigned IDX_W     = idx_width(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic                 grant_valid,
  output logic [IDX_W-1:0]     grant_idx
);

  int unsigned cand;

  // Walk offsets from farthest to nearest so the nearest requester is written last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = int'(NUM_CORES) - 1; k >= 0; k--) begin
      cand = 32'(ptr) + 32'(k);
      if (cand >= NUM_CORES) begin
        cand = cand - NUM_CORES;
      end
      if (req[IDX_W'(cand)]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising per-core load/store requests onto one memory port.
// One transaction in flight; completion is reported only on the memory response.
module mem_arbiter
  import gpu_pkg::*;
#(
  parameter int unsigned NUM_CORES  = 2,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CORES-1:0]            core_req_valid,
  input  logic [NUM_CORES-1:0]            core_req_write,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0] core_req_addr,
  input  logic [NUM_CORES*DATA_WIDTH-1:0] core_req_wdata,
  output logic [NUM_CORES-1:0]            core_req_ready,
  output logic [NUM_CORES-1:0]            core_resp_valid,
  output logic [DATA_WIDTH-1:0]           core_resp_rdata,
  output logic                            mem_req_valid,
  output logic                            mem_req_write,
  output logic [ADDR_WIDTH-1:0]           mem_req_addr,
  output logic [DATA_WIDTH-1:0]           mem_req_wdata,
  input  logic                            mem_req_ready,
  input  logic                            mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]           mem_resp_rdata,
  output logic                            busy
);

  localparam int unsigned IDX_W = idx_width(NUM_CORES);

  arb_state_t            state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NUM_CORES-1:0]  ready_q, ready_d;
  logic [NUM_CORES-1:0]  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  mem_valid_q, mem_valid_d;
  logic                  busy_q, busy_d;

  logic                  grant_valid;
  logic [IDX_W-1:0]      grant_idx;

  rr_picker #(
    .NUM_CORES (NUM_CORES)
  ) u_rr_picker (
    .req         (core_req_valid),
    .ptr         (ptr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    idx_d        = idx_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    ready_d      = '0;
    resp_valid_d = '0;
    rdata_d      = '0;
    mem_valid_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          idx_d              = grant_idx;
          wr_d               = core_req_write[grant_idx];
          addr_d             = core_req_addr[32'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d            = core_req_wdata[32'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
          ready_d[grant_idx] = 1'b1;
          mem_valid_d        = 1'b1;
          state_d            = ISSUE;
        end
      end
      ISSUE: begin
        // Request fields are the latch registers, so they hold until the handshake.
        if (mem_req_ready) begin
          state_d = WAIT;
        end else begin
          mem_valid_d = 1'b1;
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          resp_valid_d[idx_q] = 1'b1;
          rdata_d             = wr_q ? '0 : mem_resp_rdata;
          state_d             = RESPOND;
        end
      end
      RESPOND: begin
        if (32'(idx_q) == NUM_CORES - 1) begin
          ptr_d = '0;
        end else begin
          ptr_d = idx_q + IDX_W'(1);
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      idx_q        <= '0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ready_q      <= '0;
      resp_valid_q <= '0;
      rdata_q      <= '0;
      mem_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      idx_q        <= idx_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      mem_valid_q  <= mem_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign core_req_ready  = ready_q;
  assign core_resp_valid = resp_valid_q;
  assign core_resp_rdata = rdata_q;
  assign mem_req_valid   = mem_valid_q;
  assign mem_req_write   = wr_q;
  assign mem_req_addr    = addr_q;
  assign mem_req_wdata   = wdata_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency memory model.
module tb_mem_arbiter;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int AW = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    core_req_valid = '0;
  logic [N-1:0]    core_req_write = '0;
  logic [N*AW-1:0] core_req_addr = '0;
  logic [N*DW-1:0] core_req_wdata = '0;
  logic [N-1:0]    core_req_ready;
  logic [N-1:0]    core_resp_valid;
  logic [DW-1:0]   core_resp_rdata;
  logic            mem_req_valid;
  logic            mem_req_write;
  logic [AW-1:0]   mem_req_addr;
  logic [DW-1:0]   mem_req_wdata;
  logic            mem_req_ready;
  logic            mem_resp_valid;
  logic [DW-1:0]   mem_resp_rdata;
  logic            busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Memory model: handshake captured on posedge, response one cycle later.
  logic [DW-1:0] mem [16];
  logic          model_rv = 1'b0;
  logic [DW-1:0] model_rd = '0;
  bit            model_en = 1'b1;
  bit            mem_ready_en = 1'b1;
  logic          inj_rv = 1'b0;
  int            hs_cnt = 0;
  logic [AW-1:0] hs_addr[$];

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(i + 2);
  end

  always @(posedge clk) begin
    model_rv <= 1'b0;
    if (mem_req_valid && mem_req_ready) begin
      hs_cnt <= hs_cnt + 1;
      hs_addr.push_back(mem_req_addr);
      model_rd <= mem[mem_req_addr];
      if (mem_req_write) mem[mem_req_addr] <= mem_req_wdata;
      model_rv <= model_en;
    end
  end

  assign mem_req_ready  = mem_ready_en;
  assign mem_resp_valid = model_rv | inj_rv;
  assign mem_resp_rdata = model_rv ? model_rd : 8'hEE;

  mem_arbiter #(.NUM_CORES(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .reset           (reset),
    .core_req_valid  (core_req_valid),
    .core_req_write  (core_req_write),
    .core_req_addr   (core_req_addr),
    .core_req_wdata  (core_req_wdata),
    .core_req_ready  (core_req_ready),
    .core_resp_valid (core_resp_valid),
    .core_resp_rdata (core_resp_rdata),
    .mem_req_valid   (mem_req_valid),
    .mem_req_write   (mem_req_write),
    .mem_req_addr    (mem_req_addr),
    .mem_req_wdata   (mem_req_wdata),
    .mem_req_ready   (mem_req_ready),
    .mem_resp_valid  (mem_resp_valid),
    .mem_resp_rdata  (mem_resp_rdata),
    .busy            (busy)
  );

  // Core-side driver: drops valid on ready, records grants and responses.
  int          g_order[16];
  int          g_cnt;
  logic [DW-1:0] r_data[16];
  logic [N-1:0]  r_vec[16];
  int          r_cnt;

  task automatic serve(input int n_resp, input bit rearm, input int max_cyc, output bit to);
    g_cnt = 0;
    r_cnt = 0;
    to    = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (core_req_ready[i]) begin
          core_req_valid[i] = 1'b0;
          if (g_cnt < 16) g_order[g_cnt] = i;
          g_cnt++;
        end
        if (core_resp_valid[i]) begin
          if (r_cnt < 16) begin
            r_data[r_cnt] = core_resp_rdata;
            r_vec[r_cnt]  = core_resp_valid;
          end
          r_cnt++;
          if (rearm && (g_cnt + $countones(core_req_valid) < n_resp)) core_req_valid[i] = 1'b1;
        end
      end
      if (r_cnt >= n_resp) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  function automatic logic [26:0] out_snap();
    return {core_req_ready, core_resp_valid, core_resp_rdata, mem_req_valid,
            mem_req_write, mem_req_addr, mem_req_wdata, busy};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (out_snap() !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", out_snap(), 27'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_single_load();
    core_req_write = 2'b00;
    core_req_addr  = {4'd0, 4'd3};
    core_req_valid = 2'b01;
    @(negedge clk);
    checks++;
    if ({core_req_ready, mem_req_valid, mem_req_addr, busy} !== {2'b01, 1'b1, 4'd3, 1'b1}) begin
      errors++;
      $display("FAIL load_grant: ready=%b mreq=%b addr=%0d busy=%b expected 01 1 3 1",
               core_req_ready, mem_req_valid, mem_req_addr, busy);
    end
    core_req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if ({core_req_ready, mem_req_valid, busy} !== {2'b00, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL load_wait: ready=%b mreq=%b busy=%b expected 00 0 1",
               core_req_ready, mem_req_valid, busy);
    end
    @(negedge clk);
    checks++;
    if ({core_resp_valid, core_resp_rdata} !== {2'b01, 8'd5}) begin
      errors++;
      $display("FAIL load_resp: valid=%b rdata=%0d expected 01 5", core_resp_valid, core_resp_rdata);
    end
    @(negedge clk);
    checks++;
    if ({core_resp_valid, busy} !== {2'b00, 1'b0}) begin
      errors++;
      $display("FAIL load_done: valid=%b busy=%b expected 00 0", core_resp_valid, busy);
    end
  endtask

  task automatic test_concurrent_stores();
    bit to;
    int h0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    h0 = hs_addr.size();
    core_req_write = 2'b11;
    core_req_addr  = {4'd9, 4'd8};
    core_req_wdata = {8'd9, 8'd8};
    core_req_valid = 2'b11;
    serve(2, 1'b0, 40, to);
    checks++;
    if (to !== 1'b0) begin
      errors++;
      $display("FAIL stores_timeout: responses=%0d expected 2", r_cnt);
    end
    checks++;
    if (g_order[0] != 0 || g_order[1] != 1) begin
      errors++;
      $display("FAIL stores_order: got %0d,%0d expected 0,1", g_order[0], g_order[1]);
    end
    checks++;
    if (hs_addr.size() < h0 + 2 || hs_addr[h0] !== 4'd8 || hs_addr[h0+1] !== 4'd9) begin
      errors++;
      $display("FAIL stores_mem_addr: handshakes=%0d expected addr 8 then 9", hs_addr.size() - h0);
    end
    checks++;
    if (mem[8] !== 8'd8 || mem[9] !== 8'd9) begin
      errors++;
      $display("FAIL stores_mem_data: mem8=%0d mem9=%0d expected 8 9", mem[8], mem[9]);
    end
    checks++;
    if (r_data[0] !== 8'd0 || r_data[1] !== 8'd0) begin
      errors++;
      $display("FAIL stores_rdata: got %0d,%0d expected 0,0", r_data[0], r_data[1]);
    end
  endtask

  task automatic test_fairness();
    bit to;
    core_req_write = 2'b00;
    core_req_addr  = {4'd2, 4'd1};
    core_req_valid = 2'b11;
    serve(6, 1'b1, 100, to);
    checks++;
    if (to !== 1'b0) begin
      errors++;
      $display("FAIL fair_timeout: responses=%0d expected 6", r_cnt);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (g_order[k] != (k % 2) || r_vec[k] !== ((k % 2) ? 2'b10 : 2'b01) ||
          r_data[k] !== ((k % 2) ? 8'd4 : 8'd3)) begin
        errors++;
        $display("FAIL fair_txn%0d: grant=%0d resp=%b rdata=%0d expected %0d %b %0d", k,
                 g_order[k], r_vec[k], r_data[k], k % 2, (k % 2) ? 2'b10 : 2'b01,
                 (k % 2) ? 4 : 3);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit to;
    bit extra;
    int h0;
    h0 = hs_cnt;
    mem_ready_en   = 1'b0;
    core_req_write = 2'b01;
    core_req_addr  = {4'd0, 4'd5};
    core_req_wdata = {8'd0, 8'hA5};
    core_req_valid = 2'b01;
    @(negedge clk);
    checks++;
    if (core_req_ready !== 2'b01) begin
      errors++;
      $display("FAIL bp_grant: ready=%b expected 01", core_req_ready);
    end
    core_req_valid = 2'b00;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata} !== {1'b1, 1'b1, 4'd5, 8'hA5}) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b write=%b addr=%0d wdata=%h expected 1 1 5 a5",
                 c, mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata);
      end
    end
    mem_ready_en = 1'b1;
    serve(1, 1'b0, 20, to);
    checks++;
    if (to !== 1'b0 || r_vec[0] !== 2'b01) begin
      errors++;
      $display("FAIL bp_resp: timeout=%b resp=%b expected 0 01", to, r_vec[0]);
    end
    extra = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (core_resp_valid !== 2'b00) extra = 1'b1;
    end
    checks++;
    if (extra || hs_cnt - h0 != 1 || mem[5] !== 8'hA5) begin
      errors++;
      $display("FAIL bp_single: extra_resp=%b handshakes=%0d mem5=%h expected 0 1 a5",
               extra, hs_cnt - h0, mem[5]);
    end
  endtask

  task automatic test_reset_in_wait();
    bit to;
    bit seen;
    model_en       = 1'b0;
    core_req_write = 2'b00;
    core_req_addr  = {4'd2, 4'd0};
    core_req_valid = 2'b10;
    @(negedge clk);
    checks++;
    if (core_req_ready !== 2'b10) begin
      errors++;
      $display("FAIL rw_grant: ready=%b expected 10", core_req_ready);
    end
    core_req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if ({busy, mem_req_valid} !== 2'b10) begin
      errors++;
      $display("FAIL rw_in_wait: busy=%b mreq=%b expected 1 0", busy, mem_req_valid);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (out_snap() !== 27'd0) begin
      errors++;
      $display("FAIL rw_async_clear: got %h expected %h", out_snap(), 27'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    inj_rv = 1'b1;
    @(negedge clk);
    inj_rv = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (core_resp_valid !== 2'b00 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rw_no_resp: late response produced activity, expected none");
    end
    model_en       = 1'b1;
    core_req_addr  = {4'd2, 4'd1};
    core_req_valid = 2'b11;
    serve(2, 1'b0, 40, to);
    checks++;
    if (to !== 1'b0 || g_order[0] != 0) begin
      errors++;
      $display("FAIL rw_ptr_cleared: timeout=%b first_grant=%0d expected 0 0", to, g_order[0]);
    end
  endtask

  task automatic test_stray_response();
    logic [26:0] snap;
    @(negedge clk);
    snap   = out_snap();
    inj_rv = 1'b1;
    @(negedge clk);
    inj_rv = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (out_snap() !== snap || busy !== 1'b0) begin
        errors++;
        $display("FAIL stray_cycle%0d: got %h busy=%b expected %h busy=0", c, out_snap(), busy, snap);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_concurrent_stores();
    test_fairness();
    test_backpressure();
    test_reset_in_wait();
    test_stray_response();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
